// File: rtl/mod_seq.sv
// mod_seq: job sequencer for an operation core.
//
// Accepts one descriptor at a time, holds the cores in reset for two load
// cycles, enables them in RUN until they signal end-of-operation (m_endn low)
// or the job is aborted, then presents a completion record until consumed.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   job_valid/job_ready      descriptor handshake (job_dc, job_id)
//   abort                    kill the current job (LOAD1, LOAD2, RUN)
//   m_reset, m_enable, dc    controls and latched descriptor to the cores
//   m_endn                   active-low end-of-operation from the cores
//   done_valid/done_ready    completion handshake (done_id, done_status)
//   busy                     high whenever not IDLE
//   job_cnt                  completions consumed, wraps at 16 bits
//
// Optional feature: define MOD_SEQ_WDOG_EN to build a TMO_W-bit RUN watchdog
// that ends a stalled job with status 10.

module mod_seq #(
  parameter int TMO_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_dc,
  input  logic [3:0]  job_id,
  input  logic        abort,
  output logic        m_reset,
  output logic        m_enable,
  output logic [23:0] dc,
  input  logic        m_endn,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [3:0]  done_id,
  output logic [1:0]  done_status,
  output logic        busy,
  output logic [15:0] job_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD1,
    LOAD2,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORTED = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] status_nxt;
  logic       wdog_hit;

`ifdef MOD_SEQ_WDOG_EN
  logic [TMO_W-1:0] wdog_cnt;

  // Cleared in LOAD2 so it reads zero on the first RUN cycle, then counts
  // RUN cycles; all-ones marks the last RUN cycle before a timeout.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdog_cnt <= '0;
    end else if (state == LOAD2) begin
      wdog_cnt <= '0;
    end else if (state == RUN) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wdog_hit = &wdog_cnt;
`else
  assign wdog_hit = 1'b0;
`endif

  // State and record registers; dc and done_id only move on acceptance.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      dc          <= '0;
      done_id     <= '0;
      done_status <= ST_OK;
      job_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      done_status <= status_nxt;
      if (state == IDLE && job_valid) begin
        dc      <= job_dc;
        done_id <= job_id;
      end
      if (state == DONE && done_ready) begin
        job_cnt <= job_cnt + 16'd1;
      end
    end
  end

  // Next state and status. In RUN, completion beats abort, which beats the
  // watchdog timeout.
  always_comb begin
    state_nxt  = state;
    status_nxt = done_status;
    case (state)
      IDLE: begin
        if (job_valid) state_nxt = LOAD1;
      end
      LOAD1: begin
        if (abort) begin
          state_nxt  = DONE;
          status_nxt = ST_ABORTED;
        end else begin
          state_nxt = LOAD2;
        end
      end
      LOAD2: begin
        if (abort) begin
          state_nxt  = DONE;
          status_nxt = ST_ABORTED;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!m_endn) begin
          state_nxt  = DONE;
          status_nxt = ST_OK;
        end else if (abort) begin
          state_nxt  = DONE;
          status_nxt = ST_ABORTED;
        end else if (wdog_hit) begin
          state_nxt  = DONE;
          status_nxt = ST_TIMEOUT;
        end
      end
      DONE: begin
        if (done_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State-decoded outputs, forced to their idle values while reset is held
  // so the cores are quiesced even in the first reset cycle.
  always_comb begin
    job_ready  = 1'b0;
    m_reset    = 1'b1;
    m_enable   = 1'b0;
    done_valid = 1'b0;
    busy       = 1'b0;
    if (!wb_rst_i) begin
      job_ready  = (state == IDLE);
      m_reset    = (state != RUN);
      m_enable   = (state == RUN);
      done_valid = (state == DONE);
      busy       = (state != IDLE);
    end
  end

endmodule

// File: doc/mod_seq.md
MOD_SEQ -- requirements
Module: mod_seq

Interface
REQ-001 SHALL have parameter TMO_W, default 16: watchdog counter width in bits.
REQ-002 SHALL have port wb_clk_i  input  1: single clock; all logic on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port job_valid  input  1: descriptor offered.
REQ-005 SHALL have port job_ready  output  1: descriptor accepted when job_valid && job_ready.
REQ-006 SHALL have port job_dc  input  24: operation descriptor word; bit 5 selects encode.
REQ-007 SHALL have port job_id  input  4: tag returned with the completion.
REQ-008 SHALL have port abort  input  1: single-cycle request to kill the current job.
REQ-009 SHALL have port m_reset  output  1: reset to the operation cores.
REQ-010 SHALL have port m_enable  output  1: enable to the operation cores.
REQ-011 SHALL have port dc  output  24: latched descriptor driven to the cores.
REQ-012 SHALL have port m_endn  input  1: active-low end-of-operation from the cores.
REQ-013 SHALL have port done_valid  output  1: completion record valid.
REQ-014 SHALL have port done_ready  input  1: completion consumed when done_valid && done_ready.
REQ-015 SHALL have port done_id  output  4: tag of the completed job.
REQ-016 SHALL have port done_status  output  2: 00 ok, 01 aborted, 10 timeout, 11 reserved.
REQ-017 SHALL have port busy  output  1: high in every state except IDLE.
REQ-018 SHALL have port job_cnt  output  16: count of completions consumed; wraps 0xFFFF->0x0000.

Function
REQ-019 SHALL implement states IDLE, LOAD1, LOAD2, RUN and DONE.
REQ-020 SHALL drive job_ready=1 only in IDLE, combinationally from state.
REQ-021 SHALL, on acceptance in IDLE at cycle T, latch job_dc into dc and job_id into done_id at T+1 and enter LOAD1.
REQ-022 SHALL hold m_reset=1 in IDLE, LOAD1, LOAD2 and DONE, and m_reset=0 only in RUN.
REQ-023 SHALL go LOAD1->LOAD2->RUN unconditionally, so the first RUN cycle (m_enable=1, m_reset=0) is T+3.
REQ-024 SHALL drive m_enable=1 only in RUN.
REQ-025 SHALL, when m_endn is sampled 0 in RUN at cycle R, enter DONE at R+1 with done_status=00, m_enable=0 and done_valid=1.
REQ-026 SHALL ignore m_endn outside RUN.
REQ-027 SHALL, on abort in LOAD1, LOAD2 or RUN, enter DONE next cycle with done_status=01.
REQ-028 SHALL ignore abort in IDLE and DONE.
REQ-029 SHALL give completion priority when m_endn=0 and abort=1 occur in the same RUN cycle (status 00).
REQ-030 SHALL hold done_valid, done_id and done_status stable in DONE until done_ready=1.
REQ-031 SHALL, on the cycle done_ready=1 in DONE, increment job_cnt and return to IDLE; a new job is accepted no earlier than the following cycle.
REQ-032 SHALL hold dc stable from LOAD1 through DONE; dc changes only on acceptance.

Reset
REQ-033 SHALL, while wb_rst_i=1, force state IDLE and drive m_reset=1, m_enable=0, dc=0, done_valid=0, done_id=0, done_status=00, job_cnt=0, busy=0, with job_ready=0 while reset is asserted.
REQ-034 SHALL treat reset asserted in any state, including mid-RUN, as an immediate abandon: no completion record is produced.

Configuration
REQ-035 SHALL compile the watchdog only when macro MOD_SEQ_WDOG_EN is defined.
REQ-036 SHALL, with MOD_SEQ_WDOG_EN defined, clear a TMO_W-bit counter on RUN entry and increment it each RUN cycle.
REQ-037 SHALL, with MOD_SEQ_WDOG_EN defined, enter DONE with status 10 when the counter equals all-ones and m_endn=1 and abort=0 in that cycle.
REQ-038 SHALL, with MOD_SEQ_WDOG_EN defined, give precedence in the order completion (00), then abort (01), then timeout (10).
REQ-039 SHALL, without MOD_SEQ_WDOG_EN, contain no counter, so RUN waits indefinitely and status 10 is never produced.

Verification
REQ-040 SHALL cover: job_dc=0x000020, id=3 accepted at T, m_endn=0 at T+10 -> dc=0x000020 at T+1, m_enable=1 at T+3..T+10, done_valid=1 with id 3 and status 00 at T+11.
REQ-041 SHALL cover: done_ready held 0 for 5 cycles after DONE entry -> outputs stable and job_ready=0 throughout; job_cnt 0->1 after the handshake.
REQ-042 SHALL cover: abort=1 in LOAD2 -> DONE with status 01 next cycle and m_enable never 1; abort=1 with m_endn=0 in the same RUN cycle -> status 00.
REQ-043 SHALL cover: m_endn pulsed 0 in IDLE and in DONE -> no state change.
REQ-044 SHALL cover: wb_rst_i=1 for one cycle mid-RUN -> next cycle IDLE, m_reset=1, m_enable=0, done_valid=0, job_cnt=0.
REQ-045 SHALL cover: with MOD_SEQ_WDOG_EN and TMO_W=4, m_endn held 1 -> status 10 after 16 RUN cycles; without the macro, still in RUN after 100 cycles.
